// File: rtl/control_unit.sv
// Multicycle sequencer for the 8-bit CPU: fetch, decode, execute, writeback, halt.
// Optional macro CU_BRANCH_EN enables BZ/JMP; without it those opcodes are illegal.
module control_unit #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] imem_data,
    input  logic       imem_ready,
    input  logic [7:0] rs_data,
    input  logic       zero_flag,
    output logic [7:0] pc,
    output logic [1:0] alu_op,
    output logic       imm_sel,
    output logic [1:0] imm2,
    output logic [1:0] rf_raddr1,
    output logic [1:0] rf_raddr2,
    output logic [1:0] rf_waddr,
    output logic       rf_we,
    output logic       z_q,
    output logic       halted,
    output logic       illegal
);

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_NAND = 2'b10;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_NAND = 4'b0011;
    localparam logic [3:0] OP_ADDI = 4'b0100;
    localparam logic [3:0] OP_SUBI = 4'b0101;
    localparam logic [3:0] OP_BZ   = 4'b0110;
    localparam logic [3:0] OP_JMP  = 4'b0111;
    localparam logic [3:0] OP_HLT  = 4'b1111;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK,
        S_HALT
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] ir, ir_nxt;
    logic [7:0] pc_nxt;
    logic       z_q_nxt;
    logic       rf_we_q, rf_we_nxt;

    logic [3:0] opcode;
    logic       is_alu, is_bz, is_jmp, is_hlt, is_legal;

    assign opcode = ir[7:4];

    // Instruction decode; ALU controls follow ir in every state
    always_comb begin
        alu_op   = ALU_ADD;
        imm_sel  = 1'b0;
        is_alu   = 1'b0;
        is_bz    = 1'b0;
        is_jmp   = 1'b0;
        is_hlt   = 1'b0;
        is_legal = 1'b1;
        case (opcode)
            OP_NOP:  ;
            OP_ADD:  is_alu = 1'b1;
            OP_SUB:  begin is_alu = 1'b1; alu_op = ALU_SUB;  end
            OP_NAND: begin is_alu = 1'b1; alu_op = ALU_NAND; end
            OP_ADDI: begin is_alu = 1'b1; imm_sel = 1'b1; end
            OP_SUBI: begin is_alu = 1'b1; imm_sel = 1'b1; alu_op = ALU_SUB; end
`ifdef CU_BRANCH_EN
            OP_BZ:   is_bz  = 1'b1;
            OP_JMP:  is_jmp = 1'b1;
`else
            OP_BZ:   is_legal = 1'b0;
            OP_JMP:  is_legal = 1'b0;
`endif
            OP_HLT:  is_hlt = 1'b1;
            default: is_legal = 1'b0;
        endcase
    end

    assign imm2      = ir[1:0];
    assign rf_raddr1 = ir[3:2];
    assign rf_raddr2 = ir[1:0];
    assign rf_waddr  = ir[3:2];

    // Reset kills a pending write in the same cycle it is raised
    assign rf_we   = rf_we_q & ~rst;
    assign halted  = (state == S_HALT);
    assign illegal = (state == S_DECODE) & ~is_legal;

    // Next-state and next-register logic
    always_comb begin
        state_nxt = state;
        ir_nxt    = ir;
        pc_nxt    = pc;
        z_q_nxt   = z_q;
        rf_we_nxt = 1'b0;
        case (state)
            S_FETCH: begin
                if (imem_ready) begin
                    ir_nxt    = imem_data;
                    pc_nxt    = pc + 8'd1;
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                state_nxt = is_hlt ? S_HALT : S_EXECUTE;
            end
            S_EXECUTE: begin
                if (is_jmp || (is_bz && z_q)) begin
                    pc_nxt = rs_data;
                end
                if (is_alu) begin
                    state_nxt = S_WRITEBACK;
                    rf_we_nxt = 1'b1;
                end else begin
                    state_nxt = S_FETCH;
                end
            end
            S_WRITEBACK: begin
                z_q_nxt   = zero_flag;
                state_nxt = S_FETCH;
            end
            S_HALT: begin
                state_nxt = S_HALT;
            end
            default: begin
                state_nxt = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_FETCH;
            ir      <= 8'h00;
            pc      <= RESET_PC;
            z_q     <= 1'b0;
            rf_we_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            ir      <= ir_nxt;
            pc      <= pc_nxt;
            z_q     <= z_q_nxt;
            rf_we_q <= rf_we_nxt;
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit with a small register file/ALU model and a writeback scoreboard.
module tb_control_unit;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_NAND = 2'b10;
`ifdef CU_BRANCH_EN
    localparam bit BR = 1'b1;
`else
    localparam bit BR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] imem_data;
    logic       imem_ready;
    logic [7:0] rs_data;
    logic       zero_flag;
    logic [7:0] pc;
    logic [1:0] alu_op;
    logic       imm_sel;
    logic [1:0] imm2;
    logic [1:0] rf_raddr1;
    logic [1:0] rf_raddr2;
    logic [1:0] rf_waddr;
    logic       rf_we;
    logic       z_q;
    logic       halted;
    logic       illegal;

    control_unit #(.RESET_PC(8'h00)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_data  (imem_data),
        .imem_ready (imem_ready),
        .rs_data    (rs_data),
        .zero_flag  (zero_flag),
        .pc         (pc),
        .alu_op     (alu_op),
        .imm_sel    (imm_sel),
        .imm2       (imm2),
        .rf_raddr1  (rf_raddr1),
        .rf_raddr2  (rf_raddr2),
        .rf_waddr   (rf_waddr),
        .rf_we      (rf_we),
        .z_q        (z_q),
        .halted     (halted),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    // Register file and ALU around the sequencer
    logic [7:0] regs [4];
    logic [7:0] op2, alu_res;
    logic       pre_we;
    logic [1:0] pre_addr;
    logic [7:0] pre_data;

    always_comb begin
        op2 = imm_sel ? {6'b0, imm2} : regs[rf_raddr2];
        case (alu_op)
            ALU_ADD:  alu_res = regs[rf_raddr1] + op2;
            ALU_SUB:  alu_res = regs[rf_raddr1] - op2;
            ALU_NAND: alu_res = ~(regs[rf_raddr1] & op2);
            default:  alu_res = 8'h00;
        endcase
        zero_flag = (alu_res == 8'h00);
        rs_data   = regs[rf_raddr2];
    end

    always @(posedge clk) begin
        if (pre_we)     regs[pre_addr] <= pre_data;
        else if (rf_we) regs[rf_waddr] <= alu_res;
    end

    typedef struct packed {
        logic [1:0] addr;
        logic [7:0] data;
    } wb_t;

    wb_t sb[$];
    wb_t exp_wb;
    int  errors = 0;
    int  checks = 0;
    logic [7:0] exp_pc;

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    // Advance one cycle and retire any register write against the scoreboard
    task automatic tick();
        @(posedge clk);
        #1;
        if (rf_we) begin
            chk1("sb_write_expected", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
                exp_wb = sb.pop_front();
                chk8("sb_waddr", {6'b0, rf_waddr}, {6'b0, exp_wb.addr});
                chk8("sb_wdata", alu_res, exp_wb.data);
            end
        end
    endtask

    task automatic preload(input logic [1:0] a, input logic [7:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        tick();
        pre_we   = 1'b0;
    endtask

    task automatic fetch(input logic [7:0] instr);
        imem_data  = instr;
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        exp_pc     = exp_pc + 8'd1;
    endtask

    initial begin
        rst        = 1'b1;
        imem_data  = 8'h00;
        imem_ready = 1'b0;
        pre_we     = 1'b0;
        pre_addr   = 2'd0;
        pre_data   = 8'h00;
        exp_pc     = 8'h00;
        preload(2'd0, 8'h00);
        preload(2'd1, 8'd10);
        preload(2'd2, 8'd5);
        preload(2'd3, 8'h00);

        // Reset state
        chk8("rst_pc", pc, 8'h00);
        chk1("rst_z_q", z_q, 1'b0);
        chk1("rst_rf_we", rf_we, 1'b0);
        chk1("rst_halted", halted, 1'b0);
        chk1("rst_illegal", illegal, 1'b0);
        chk8("rst_alu_op", {6'b0, alu_op}, {6'b0, ALU_ADD});
        chk1("rst_imm_sel", imm_sel, 1'b0);
        chk8("rst_imm2", {6'b0, imm2}, 8'h00);
        rst = 1'b0;

        // ADD R1,R2
        fetch(8'h16);
        chk8("add_pc_decode", pc, 8'h01);
        chk1("add_illegal", illegal, 1'b0);
        tick();
        chk8("add_alu_op", {6'b0, alu_op}, {6'b0, ALU_ADD});
        chk1("add_imm_sel", imm_sel, 1'b0);
        chk1("add_rf_we_exec", rf_we, 1'b0);
        sb.push_back('{addr: 2'd1, data: 8'd15});
        tick();
        chk1("add_rf_we_wb", rf_we, 1'b1);
        chk8("add_waddr", {6'b0, rf_waddr}, 8'd1);
        tick();
        chk1("add_rf_we_after", rf_we, 1'b0);
        chk8("add_pc", pc, 8'h01);
        chk1("add_z_q", z_q, 1'b0);

        // SUBI R0,3 with R0=3 gives zero
        preload(2'd0, 8'd3);
        fetch(8'h53);
        tick();
        chk1("subi_imm_sel", imm_sel, 1'b1);
        chk8("subi_imm2", {6'b0, imm2}, 8'd3);
        chk8("subi_alu_op", {6'b0, alu_op}, {6'b0, ALU_SUB});
        chk1("subi_zero_flag", zero_flag, 1'b1);
        sb.push_back('{addr: 2'd0, data: 8'h00});
        tick();
        tick();
        chk1("subi_z_q", z_q, 1'b1);
        chk8("subi_pc", pc, 8'h02);

        // BZ R2 with z_q=1
        preload(2'd2, 8'h40);
        fetch(8'h62);
        chk1("bz1_illegal", illegal, !BR);
        tick();
        chk1("bz1_illegal_exec", illegal, 1'b0);
        tick();
        if (BR) exp_pc = 8'h40;
        chk8("bz1_pc", pc, exp_pc);
        chk1("bz1_z_q_hold", z_q, 1'b1);

        // ADDI R1,1 clears z_q
        fetch(8'h45);
        tick();
        sb.push_back('{addr: 2'd1, data: 8'd16});
        tick();
        tick();
        chk1("addi_z_q", z_q, 1'b0);
        chk8("addi_pc", pc, exp_pc);

        // BZ R2 with z_q=0 falls through
        fetch(8'h62);
        chk1("bz0_illegal", illegal, !BR);
        tick();
        tick();
        chk8("bz0_pc", pc, exp_pc);

        // JMP R2
        fetch(8'h72);
        chk1("jmp_illegal", illegal, !BR);
        tick();
        tick();
        if (BR) exp_pc = 8'h40;
        chk8("jmp_pc", pc, exp_pc);

        // Stall in FETCH
        for (int i = 0; i < 5; i++) begin
            tick();
            chk8("stall_pc", pc, exp_pc);
            chk1("stall_rf_we", rf_we, 1'b0);
            chk8("stall_ir", {4'b0, rf_raddr1, imm2}, 8'h02);
        end
        fetch(8'h00);
        chk8("post_stall_pc", pc, exp_pc);
        chk8("post_stall_ir", {4'b0, rf_raddr1, imm2}, 8'h00);
        tick();
        tick();

        // Undefined opcode
        fetch(8'h80);
        chk1("ill_pulse", illegal, 1'b1);
        chk8("ill_pc", pc, exp_pc);
        tick();
        chk1("ill_pulse_end", illegal, 1'b0);
        tick();

        // HLT, then hold with imem_ready high
        fetch(8'hF0);
        chk1("hlt_decode_halted", halted, 1'b0);
        chk1("hlt_illegal", illegal, 1'b0);
        tick();
        chk1("hlt_halted", halted, 1'b1);
        imem_data  = 8'h16;
        imem_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk8("halt_pc", pc, exp_pc);
            chk1("halt_state", halted, 1'b1);
            chk1("halt_rf_we", rf_we, 1'b0);
        end
        imem_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk1("halt_exit", halted, 1'b0);
        chk8("halt_rst_pc", pc, 8'h00);
        chk1("halt_rst_z_q", z_q, 1'b0);

        // Reset raised in WRITEBACK suppresses the write
        exp_pc = 8'h00;
        fetch(8'h16);
        tick();
        @(posedge clk);
        #1;
        chk1("wbrst_in_wb", rf_we, 1'b1);
        rst = 1'b1;
        #1;
        chk1("wbrst_we_gated", rf_we, 1'b0);
        tick();
        rst = 1'b0;
        chk8("wbrst_pc", pc, 8'h00);
        chk8("wbrst_r1_kept", regs[1], 8'd16);
        chk1("wbrst_rf_we", rf_we, 1'b0);
        chk8("wbrst_ir", {4'b0, rf_raddr1, imm2}, 8'h00);

        // NOP stream up to pc=FF, then wrap
        imem_data  = 8'h00;
        imem_ready = 1'b1;
        for (int i = 0; i < 765; i++) tick();
        chk8("wrap_pre_pc", pc, 8'hFF);
        tick();
        chk8("wrap_pc", pc, 8'h00);
        imem_ready = 1'b0;

        chk8("sb_drained", 8'(sb.size()), 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/control_unit.md
# control_unit

Multicycle sequencer for the 8-bit CPU, directly upstream of `alu`. Fetches an 8-bit instruction, decodes it into the ALU controls (`alu_op`, `imm_sel`, `imm2`) and register-file selects, commits the ALU `result` through the register-file write strobe, and latches the ALU `zero_flag` for conditional branches. It owns the program counter and the instruction register.

## Interface
- `RESET_PC`, default `8'h00`: PC value loaded on reset.

- `clk`  in  1  system clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `imem_data`  in  8  instruction at address `pc`
- `imem_ready`  in  1  `imem_data` is valid this cycle
- `rs_data`  in  8  register-file read port 2 data, used as the jump target
- `zero_flag`  in  1  ALU zero flag, combinational
- `pc`  out  8  fetch address
- `alu_op`  out  2  ALU operation (`ALU_ADD`/`ALU_SUB`/`ALU_NAND` from `defines.vh`)
- `imm_sel`  out  1  1 selects `imm2` as ALU operand 2
- `imm2`  out  2  immediate, equal to `ir[1:0]`
- `rf_raddr1`  out  2  source 1 / destination, equal to `ir[3:2]`
- `rf_raddr2`  out  2  source 2, equal to `ir[1:0]`
- `rf_waddr`  out  2  equal to `ir[3:2]`
- `rf_we`  out  1  register-file write strobe
- `z_q`  out  1  latched zero flag
- `halted`  out  1  high in HALT
- `illegal`  out  1  one-cycle pulse on an undefined opcode

## Operation
- Instruction format: `[7:4]` opcode, `[3:2]` rd (also source 1), `[1:0]` rs or imm2.
- `0000` NOP
- `0001` ADD rd,rs
- `0010` SUB rd,rs (rd−rs)
- `0011` NAND rd,rs
- `0100` ADDI rd,imm2
- `0101` SUBI rd,imm2
- `0110` BZ rs: if `z_q`, then `pc <= rs_data`
- `0111` JMP rs: `pc <= rs_data`
- `1111` HLT
- Any other opcode behaves as NOP and pulses `illegal` in DECODE.
- States: FETCH → DECODE → EXECUTE → (WRITEBACK for ALU ops only) → FETCH. HLT goes to HALT.
- FETCH: waits while `imem_ready=0`. When `imem_ready=1`: `ir <= imem_data`, `pc <= pc+1` (wraps `8'hFF` → `8'h00`), go to DECODE.
- DECODE: classifies the opcode. `illegal` is asserted here only.
- EXECUTE: the ALU inputs settle. BZ/JMP load `pc` at the end of this cycle, then FETCH. NOP/illegal go to FETCH.
- WRITEBACK: `rf_we=1` for exactly this cycle; `z_q <= zero_flag` at its end. Then FETCH.
- `z_q` is updated only by ALU ops. Branches, NOP and HLT hold it.
- `alu_op`/`imm_sel`/`imm2` are decoded combinationally from `ir` in every state. They are stable across EXECUTE and WRITEBACK. Non-ALU opcodes drive `ALU_ADD`, `imm_sel=0`.
- HALT is absorbing: `pc` frozen, `rf_we=0`. Only `rst` exits it.

## Timing
- Reset values: `pc=RESET_PC`, `ir=8'h00` (so the ALU controls decode to ADD, `imm_sel=0`, `imm2=0`), state FETCH, `z_q=0`, `rf_we=0`, `halted=0`, `illegal=0`.
- Latency with `imem_ready` held high:
  - ALU op: 4 cycles
  - NOP/branch/illegal: 3 cycles
  - HLT: 2 cycles, then `halted=1` from the next cycle
- Reset asserted in any state, including mid-WRITEBACK: the pending write is suppressed (`rf_we=0` while `rst=1`). The next state is FETCH with reset values.
- `imem_ready` is sampled only in FETCH and ignored elsewhere.
- BZ with `z_q` written by the immediately preceding instruction uses the new value. There is no hazard, since WRITEBACK completes before the next FETCH.

## Configuration
- `CU_BRANCH_EN` defined: BZ and JMP are implemented as above.
- Undefined: opcodes `0110`/`0111` are illegal. They act as NOP with an `illegal` pulse, and `pc` only increments.

## Test plan
- ADD: reset, R1=10, R2=5, `imem_data=8'h16` (ADD R1,R2), `imem_ready=1`.
  - Required: `alu_op=ALU_ADD`, `imm_sel=0` in EXECUTE.
  - Required: `rf_we=1`, `rf_waddr=1` in cycle 4.
  - Required: `pc=8'h01`, `z_q=0`.
- SUBI to zero: R0=3, `8'h53` (SUBI R0,3).
  - Required: `imm_sel=1`, `imm2=3`, ALU `zero_flag=1`, then `z_q=1` after WRITEBACK.
- BZ (`CU_BRANCH_EN` defined): with `z_q=1`, `8'h62` and `rs_data=8'h40`.
  - Required: `pc=8'h40` after 3 cycles.
  - With `z_q=0`: `pc` advances by 1.
  - Undefined build: `illegal` pulses and `pc` advances by 1.
- Stall: hold `imem_ready=0` for 5 cycles in FETCH.
  - Required: state, `pc` and `ir` unchanged, `rf_we=0`.
  - On `imem_ready=1`, fetch proceeds normally.
- Illegal/HLT: `8'h80`.
  - Required: `illegal=1` for one cycle, `pc` increments.
  - Then `8'hF0`: `halted=1`, and `pc` is stable for 10 cycles despite `imem_ready=1`.
- Reset and wrap: `rst=1` during WRITEBACK.
  - Required: no write, `pc=RESET_PC` next cycle.
  - With `pc=8'hFF` fetching NOP: `pc=8'h00`.
